apb_slave_regfile: RTL

- APB completer (responder) terminating one APB channel of the ICB-to-APB bridge; the bridge is the requester on the other end.
- Word-addressed register bank with configurable wait states. Its timing satisfies the channel's protocol checks:
  - `pready` is a single-cycle pulse.
  - `prdata` is known whenever `pready` is high on a read.
- Serves as the synthesizable peripheral behind each channel in system simulation and as the reference responder for bridge verification.

---
 rtl/apb_pkg.sv | 32 +++
 rtl/apb_slave_regfile_if.sv | 21 ++
 rtl/apb_wait_ctrl.sv | 43 ++++
 rtl/apb_slave_regfile.sv | 118 +++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file responder:
// FSM state encoding, bus constants and the word-address decoder.
package apb_pkg;

   localparam int APB_STRIDE = 4;
   localparam int ERR_CNT_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef struct packed {
      logic        in_range;
      logic [15:0] idx;
   } decode_t;

   // Addresses are widened to 64 bits so one helper serves every ADDR_WIDTH;
   // the byte lane bits fall out of idx and only matter for the range test.
   function automatic decode_t addr_decode(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input int unsigned reg_num);
      logic [63:0] offset;
      decode_t     d;
      offset     = addr - base;
      d.in_range = (addr >= base) && (offset < 64'(reg_num) * 64'(APB_STRIDE));
      d.idx      = offset[17:2] & 16'(reg_num - 1);
      return d;
   endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB channel between the bridge (master) and the register-file responder (slave).
interface apb_slave_regfile_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Handshake: a transfer completes in the single cycle where psel, penable
   // and pready are all high; pready is a one-cycle pulse and prdata is only
   // meaningful in that cycle of a read.
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;

   modport master (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                   output prdata, pready);
endinterface

// File: rtl/apb_wait_ctrl.sv
// Wait-state counter for one APB transfer; produces the registered pready pulse
// and a combinational fire strobe one cycle ahead of it.
module apb_wait_ctrl #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   output logic fire,
   output logic ready
);

   logic [3:0] cnt;
   logic       active;

   // With no wait states the setup cycle itself fires, so pready lands in
   // the first access cycle.
   always_comb begin
      fire = !abort && ((start && (WAIT_CYCLES == 0)) || (active && (cnt == 4'd1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= 4'd0;
         active <= 1'b0;
         ready  <= 1'b0;
      end else begin
         ready <= fire;
         if (abort) begin
            cnt    <= 4'd0;
            active <= 1'b0;
         end else if (start) begin
            cnt    <= 4'(WAIT_CYCLES);
            active <= (WAIT_CYCLES != 0);
         end else if (active) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed RW register bank, configurable wait
// states and a saturating out-of-range access counter.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    REG_NUM     = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   apb_slave_regfile_if.slave            bus,
   output logic [REG_NUM*DATA_WIDTH-1:0] reg_q,
   output logic [ERR_CNT_W-1:0]          err_cnt,
   output state_e                        fsm_state
);

   state_e                state;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic                  hold_write;
   logic [DATA_WIDTH-1:0] hold_wdata;
   logic [DATA_WIDTH-1:0] regs [REG_NUM];
   logic [DATA_WIDTH-1:0] prdata_q;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  setup, abort, fire, ready, handshake;
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic                  eff_write;
   decode_t               dec_eff, dec_hold;

   assign setup     = (state == ST_IDLE) && bus.psel && !bus.penable;
   assign abort     = (state == ST_ACCESS) && !bus.psel;
   assign handshake = (state == ST_DONE) && bus.psel && bus.penable && ready;

   // A zero-wait transfer fires before the holding registers are loaded,
   // so the read path looks at the live bus during setup.
   assign eff_addr  = setup ? bus.paddr  : hold_addr;
   assign eff_write = setup ? bus.pwrite : hold_write;

   always_comb begin
      dec_eff  = addr_decode(64'(eff_addr),  64'(BASE_ADDR), REG_NUM);
      dec_hold = addr_decode(64'(hold_addr), 64'(BASE_ADDR), REG_NUM);
   end

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (dec_eff.in_range && (dec_eff.idx == 16'(i))) rd_val = regs[i];
      end
   end

   apb_wait_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
      .clk   (clk),
      .rst_n (rst_n),
      .start (setup),
      .abort (abort),
      .fire  (fire),
      .ready (ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (setup) state <= fire ? ST_DONE : ST_ACCESS;
            ST_ACCESS: if (abort) state <= ST_IDLE;
                       else if (fire) state <= ST_DONE;
            ST_DONE:   state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_addr  <= '0;
         hold_write <= 1'b0;
         hold_wdata <= '0;
      end else if (setup) begin
         hold_addr  <= bus.paddr;
         hold_write <= bus.pwrite;
         hold_wdata <= bus.pwdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (handshake && hold_write && dec_hold.in_range && (dec_hold.idx == 16'(i)))
               regs[i] <= hold_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prdata_q <= '0;
         err_cnt  <= '0;
      end else begin
         if (fire && !eff_write) prdata_q <= rd_val;
         if (handshake && !dec_hold.in_range && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_q
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

   assign bus.prdata = prdata_q;
   assign bus.pready = ready;
   assign fsm_state  = state;

endmodule
